// File: rtl/lab5_mmio_responder.sv
// lab5_mmio_responder: byte-wide MMIO window at the top of the data space.
// Debounced input with rise counter, switch status, LED and display registers.
`default_nettype none

module lab5_mmio_responder #(
  parameter int          DB_CYCLES = 16,
  parameter logic [7:0]  IO_BASE   = 8'hF8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic       WE,
  input  logic       RE,
  output logic [7:0] RDATA,
  output logic       HIT,
  input  logic       RAW_IN,
  input  logic [6:0] SW,
  output logic [7:0] LED_A,
  output logic [7:0] LED_B,
  output logic [7:0] DISP_CTL,
  output logic [7:0] DISP_HI,
  output logic [7:0] DISP_LO
);

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  localparam logic [2:0] OFF_EVT  = 3'd0;
  localparam logic [2:0] OFF_STAT = 3'd1;
  localparam logic [2:0] OFF_LEDA = 3'd2;
  localparam logic [2:0] OFF_LEDB = 3'd3;
  localparam logic [2:0] OFF_CTL  = 3'd5;
  localparam logic [2:0] OFF_HI   = 3'd6;
  localparam logic [2:0] OFF_LO   = 3'd7;

  logic [2:0]  offset;
  logic        in_meta, in_s;
  logic [6:0]  sw_meta, sw_s;
  logic        in_db;
  logic [15:0] db_cnt;
  logic [7:0]  evt_cnt;
  logic        db_fire;
  logic        rise;
  logic        evt_clear;
  logic        wr_en;

  assign HIT       = (ADDR[7:3] == IO_BASE[7:3]);
  assign offset    = ADDR[2:0];
  assign wr_en     = WE && HIT;
  assign evt_clear = RE && HIT && (offset == OFF_EVT);

  // The debounced level flips when the synchronized input has disagreed for DB_CYCLES edges.
  assign db_fire = (in_s != in_db) && (db_cnt == DB_LAST);
  assign rise    = db_fire && in_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_meta <= 1'b0;
      in_s    <= 1'b0;
      sw_meta <= 7'd0;
      sw_s    <= 7'd0;
    end else begin
      in_meta <= RAW_IN;
      in_s    <= in_meta;
      sw_meta <= SW;
      sw_s    <= sw_meta;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_db  <= 1'b0;
      db_cnt <= 16'd0;
    end else if (in_s == in_db) begin
      db_cnt <= 16'd0;
    end else if (db_fire) begin
      in_db  <= in_s;
      db_cnt <= 16'd0;
    end else begin
      db_cnt <= db_cnt + 16'd1;
    end
  end

  // A clearing read that coincides with a rise leaves exactly that one rise counted.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      evt_cnt <= 8'd0;
    end else if (evt_clear) begin
      evt_cnt <= {7'd0, rise};
    end else if (rise && (evt_cnt != 8'hFF)) begin
      evt_cnt <= evt_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      LED_A    <= 8'd0;
      LED_B    <= 8'd0;
      DISP_CTL <= 8'd0;
      DISP_HI  <= 8'd0;
      DISP_LO  <= 8'd0;
    end else if (wr_en) begin
      case (offset)
        OFF_LEDA: LED_A    <= WDATA;
        OFF_LEDB: LED_B    <= WDATA;
        OFF_CTL:  DISP_CTL <= WDATA;
        OFF_HI:   DISP_HI  <= WDATA;
        OFF_LO:   DISP_LO  <= WDATA;
        default:  ;
      endcase
    end
  end

  always_comb begin
    RDATA = 8'd0;
    if (RE && HIT) begin
      case (offset)
        OFF_EVT:  RDATA = evt_cnt;
        OFF_STAT: RDATA = {sw_s, in_db};
        OFF_LEDA: RDATA = LED_A;
        OFF_LEDB: RDATA = LED_B;
        OFF_CTL:  RDATA = DISP_CTL;
        OFF_HI:   RDATA = DISP_HI;
        OFF_LO:   RDATA = DISP_LO;
        default:  RDATA = 8'd0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/lab5_mmio_responder.md
Name: lab5_mmio_responder

Overview:
- Memory-mapped I/O responder for the single-cycle processor's byte data bus.
- Answers the LB/SB accesses that programs make to the top of the 8-bit data address space (0xF8–0xFF).
- Input side: synchronizes and debounces a raw pushbutton/switch bit and counts its rising edges.
- Output side: holds the LED and seven-segment display registers written by SB.
- Sits beside the data RAM; the datapath muxes RDATA in when HIT is high.

Parameters:
- DB_CYCLES, 16, consecutive stable cycles required before the debounced input changes. Legal range 1..65535.
- IO_BASE, 8'hF8, base of the 8-byte I/O window. Must be 8-byte aligned.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ADDR  input  8  data address from the ALU.
- WDATA  input  8  store data (low byte of rt).
- WE  input  1  store strobe for the current cycle (SB).
- RE  input  1  load strobe for the current cycle (LB).
- RDATA  output  8  load data; combinational.
- HIT  output  1  ADDR is inside the I/O window; combinational.
- RAW_IN  input  1  asynchronous external input bit.
- SW  input  7  asynchronous switches.
- LED_A  output  8  register at IO_BASE+2 (0xFA).
- LED_B  output  8  register at IO_BASE+3 (0xFB).
- DISP_CTL  output  8  register at IO_BASE+5 (0xFD).
- DISP_HI  output  8  register at IO_BASE+6 (0xFE).
- DISP_LO  output  8  register at IO_BASE+7 (0xFF).

Behaviour:
- Address map (offset from IO_BASE):
  - +0 EVT_CNT: read-only, clear-on-read.
  - +1 STATUS: read-only, value {SW_s[6:0], IN_db}.
  - +2 LED_A, RW.
  - +3 LED_B, RW.
  - +4 reserved: reads 0x00, writes ignored.
  - +5 DISP_CTL, RW.
  - +6 DISP_HI, RW.
  - +7 DISP_LO, RW.
- HIT = (ADDR[7:3] == IO_BASE[7:3]). Independent of WE/RE.
- RDATA:
  - Combinational from the current register state, valid in the same cycle.
  - 0x00 when HIT=0 or RE=0.
  - A read returns the pre-edge value. Register updates take effect after the rising edge.
- Writes:
  - When WE & HIT at a rising edge, the addressed RW register loads WDATA.
  - Writes to read-only or reserved offsets have no effect.
  - WE & RE together is illegal from the CPU. If it occurs, both actions happen.
- Input synchronizer:
  - Two flops on RAW_IN produce IN_s.
  - Two flops per bit on SW produce SW_s.
- Debouncer (16-bit counter DB_CNT, state IN_db):
  - If IN_s == IN_db: DB_CNT <= 0.
  - Else if DB_CNT == DB_CYCLES-1: IN_db <= IN_s and DB_CNT <= 0.
  - Else: DB_CNT <= DB_CNT+1.
  - Latency: IN_db changes on the (DB_CYCLES+2)th rising edge after the first edge that samples the new RAW_IN level, provided RAW_IN holds.
  - A glitch shorter than DB_CYCLES cycles at IN_s leaves IN_db unchanged and restarts the count.
- Event counter EVT_CNT (8 bits):
  - Rise = IN_db transitioning 0→1 at this edge.
  - Saturates at 0xFF; never wraps.
  - Clear-on-read: an edge with RE & HIT & offset 0 sets EVT_CNT to 0.
  - Simultaneous clear-read and rise: EVT_CNT becomes 0x01. The rise is never lost.
- Reset (asynchronous, any time, including mid-debounce): all outputs, sync flops, IN_db, DB_CNT and EVT_CNT become 0.
  - Outputs therefore reset to LED_A=LED_B=DISP_CTL=DISP_HI=DISP_LO=0x00.
  - HIT and RDATA follow their combinational definitions.
  - Operation resumes on the first rising edge after RESET deasserts.

Test Plan:
- Reset mid-operation:
  - Setup: DB_CYCLES=4; write 0xA5 to 0xFA; EVT_CNT=3 with DB_CNT mid-count.
  - Stimulus: assert RESET between edges.
  - Required: LED_A=0x00 immediately; a subsequent read of 0xF8 returns 0x00; a read of 0xF9 returns 0x00 with SW=0.
- Write/readback:
  - Stimulus: SB 0x3C to 0xFE, then 0x81 to 0xFF.
  - Required: DISP_HI=0x3C after the first edge and DISP_LO=0x81 after the second; LB returns the same values; a write to 0xFC then read returns 0x00; ADDR=0xF7 gives HIT=0 and RDATA=0x00.
- Debounce latency:
  - Setup: DB_CYCLES=4.
  - Stimulus: RAW_IN 0→1 held.
  - Required: IN_db rises on the 6th edge; STATUS bit0=1; EVT_CNT=1.
  - Stimulus: a 3-cycle RAW_IN pulse.
  - Required: IN_db stays 0.
- Counter saturation:
  - Stimulus: 260 clean rising events.
  - Required: read of 0xF8 returns 0xFF; the next read returns 0x00.
- Clear/rise collision:
  - Stimulus: read 0xF8 on exactly the edge where IN_db rises, with prior count 5.
  - Required: RDATA=0x05 that cycle; the next read returns 0x01.
- Switch path:
  - Stimulus: SW=7'h55 held.
  - Required: STATUS reads {7'h55, IN_db}=0xAA|IN_db from 2 edges after SW changes.
